// File: rtl/sync_fifo_p_if.sv
// Handshake and data bundle for sync_fifo_p: requester drives push/pop/data_in,
// the FIFO returns data_out qualified by data_valid.
interface sync_fifo_p_if #(
  parameter int WIDTH = 32
) ();
  logic             push;
  logic [WIDTH-1:0] data_in;
  logic             pop;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;

  modport master (
    output push, data_in, pop,
    input  data_out, data_valid
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, data_valid
  );
endinterface

// File: rtl/sync_fifo_p.sv
// Single-clock FIFO with explicit count register, status flags, sticky error and
// show-ahead/registered read. Define SYNC_FIFO_P_PEAK_EN to add the peak_count watermark.
module sync_fifo_p #(
  parameter int WIDTH           = 32,
  parameter int DEPTH_LOG2      = 4,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 4,
  parameter int READ_MODE       = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  sync_fifo_p_if.slave        bus,
  input  logic                err_clr,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                almost_empty,
  output logic                almost_full,
  output logic                full,
  output logic                overflow,
  output logic                underflow,
  output logic                error
`ifdef SYNC_FIFO_P_PEAK_EN
  ,
  input  logic                peak_clr,
  output logic [DEPTH_LOG2:0] peak_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_AF   = CNT_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0]      CNT_AE   = CNT_W'(ALMOST_EMPTY_TH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  err_q, err_d;
  logic                  push_v, pop_v;
  logic                  push_acc, pop_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_FULL);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign error        = err_q;

  always_comb begin
    // if-form so an unknown request resolves to "not requested"
    push_v = 1'b0;
    pop_v  = 1'b0;
    if (bus.push) push_v = 1'b1;
    if (bus.pop)  pop_v  = 1'b1;

    pop_acc  = pop_v && !empty;
    push_acc = push_v && (!full || pop_acc);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    ovf_d = push_v && !push_acc;
    udf_d = pop_v && !pop_acc;
    // error rises together with the pulse; a coincident clear loses
    err_d = ovf_d || udf_d || (err_q && !err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  if (READ_MODE == 0) begin : g_show_ahead
    assign bus.data_out   = mem_q[rd_ptr_q];
    assign bus.data_valid = !empty;
  end else begin : g_registered
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvld_q, dvld_d;

    always_comb begin
      dout_d = dout_q;
      if (pop_acc) dout_d = mem_q[rd_ptr_q];
      dvld_d = pop_acc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dout_q <= '0;
        dvld_q <= 1'b0;
      end else begin
        dout_q <= dout_d;
        dvld_q <= dvld_d;
      end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = dvld_q;
  end

`ifdef SYNC_FIFO_P_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (peak_clr)               peak_d = count_q;
    else if (count_q > peak_q)  peak_d = count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) peak_q <= '0;
    else          peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_sync_fifo_p.sv
// Bench for sync_fifo_p: one show-ahead and one registered instance share stimulus,
// checked every cycle against a queue model plus literal expectations.
module tb_sync_fifo_p;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        push_r = 1'b0;
  logic        pop_r = 1'b0;
  logic [31:0] din_r = '0;
  logic        err_clr_r = 1'b0;
  logic        chk_en = 1'b0;

  logic [4:0] count0, count1;
  logic empty0, aempty0, afull0, full0, ovf0, udf0, err0;
  logic empty1, aempty1, afull1, full1, ovf1, udf1, err1;
`ifdef SYNC_FIFO_P_PEAK_EN
  logic       peak_clr_r = 1'b0;
  logic [4:0] peak0, peak1;
`endif

  int npass = 0;
  int ntot  = 0;

  logic [31:0] mq[$];
  logic        m_ovf, m_udf, m_err, m_dv1;
  logic [31:0] m_dout1;

  always #5 clk = ~clk;

  sync_fifo_p_if #(.WIDTH(32)) bus0 ();
  sync_fifo_p_if #(.WIDTH(32)) bus1 ();

  assign bus0.push = push_r;
  assign bus0.pop = pop_r;
  assign bus0.data_in = din_r;
  assign bus1.push = push_r;
  assign bus1.pop = pop_r;
  assign bus1.data_in = din_r;

  sync_fifo_p #(.READ_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .err_clr(err_clr_r),
    .count(count0), .empty(empty0), .almost_empty(aempty0), .almost_full(afull0),
    .full(full0), .overflow(ovf0), .underflow(udf0), .error(err0)
`ifdef SYNC_FIFO_P_PEAK_EN
    , .peak_clr(peak_clr_r), .peak_count(peak0)
`endif
  );

  sync_fifo_p #(.READ_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .err_clr(err_clr_r),
    .count(count1), .empty(empty1), .almost_empty(aempty1), .almost_full(afull1),
    .full(full1), .overflow(ovf1), .underflow(udf1), .error(err1)
`ifdef SYNC_FIFO_P_PEAK_EN
    , .peak_clr(peak_clr_r), .peak_count(peak1)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_err = 1'b0;
    m_dv1 = 1'b0;
    m_dout1 = '0;
  endtask

  task automatic model_step(input logic p, input logic [31:0] d, input logic pp, input logic ec);
    bit pop_ok, push_ok;
    pop_ok  = pp && (mq.size() > 0);
    push_ok = p && ((mq.size() < 16) || pop_ok);
    m_ovf = p && !push_ok;
    m_udf = pp && !pop_ok;
    m_err = m_ovf || m_udf || (m_err && !ec);
    m_dv1 = pop_ok;
    if (pop_ok) begin
      m_dout1 = mq[0];
      void'(mq.pop_front());
    end
    if (push_ok) mq.push_back(d);
  endtask

  task automatic cycle(input logic p, input logic [31:0] d, input logic pp, input logic ec);
    push_r = p;
    din_r = d;
    pop_r = pp;
    err_clr_r = ec;
    @(posedge clk);
    model_step(p, d, pp, ec);
    @(negedge clk);
    push_r = 1'b0;
    pop_r = 1'b0;
    err_clr_r = 1'b0;
  endtask

  always @(negedge clk) begin : cmp
    int n;
    if (chk_en) begin
      n = mq.size();
      chk("count0", 64'(count0), 64'(n));
      chk("count1", 64'(count1), 64'(n));
      chk("empty0", 64'(empty0), 64'(n == 0));
      chk("full0", 64'(full0), 64'(n == 16));
      chk("afull0", 64'(afull0), 64'(n >= 12));
      chk("aempty0", 64'(aempty0), 64'(n <= 4));
      chk("full1", 64'(full1), 64'(n == 16));
      chk("ovf0", 64'(ovf0), 64'(m_ovf));
      chk("ovf1", 64'(ovf1), 64'(m_ovf));
      chk("udf0", 64'(udf0), 64'(m_udf));
      chk("udf1", 64'(udf1), 64'(m_udf));
      chk("err0", 64'(err0), 64'(m_err));
      chk("err1", 64'(err1), 64'(m_err));
      chk("dvalid0", 64'(bus0.data_valid), 64'(n > 0));
      if (n > 0) chk("dout0", 64'(bus0.data_out), 64'(mq[0]));
      chk("dvalid1", 64'(bus1.data_valid), 64'(m_dv1));
      chk("dout1", 64'(bus1.data_out), 64'(m_dout1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_count", 64'(count0), 64'd0);
    chk("rst_empty", 64'(empty0), 64'd1);
    chk("rst_aempty", 64'(aempty0), 64'd1);
    chk("rst_full", 64'(full0), 64'd0);
    chk("rst_afull", 64'(afull0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    chk("rst_udf", 64'(udf1), 64'd0);
    chk("rst_err", 64'(err1), 64'd0);
    chk("rst_dv1", 64'(bus1.data_valid), 64'd0);
    chk("rst_dout1", 64'(bus1.data_out), 64'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // fill with 0..15
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 10) chk("fill_af_at11", 64'(afull0), 64'd0);
      if (i == 11) chk("fill_af_at12", 64'(afull0), 64'd1);
      chk("fill_noovf", 64'(ovf0), 64'd0);
    end
    chk("fill_count", 64'(count0), 64'd16);
    chk("fill_full", 64'(full1), 64'd1);

    // overflow
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("ovf_pulse", 64'(ovf0), 64'd1);
    chk("ovf_err", 64'(err0), 64'd1);
    chk("ovf_count", 64'(count0), 64'd16);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_pulse_end", 64'(ovf1), 64'd0);
    chk("err_sticky", 64'(err1), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("err_clr", 64'(err0), 64'd0);

    // pass-through while full
    for (int i = 0; i < 4; i++) begin
      chk("pt_head0", 64'(bus0.data_out), 64'(i));
      cycle(1'b1, 32'hABCD_EF01, 1'b1, 1'b0);
      chk("pt_dout1", 64'(bus1.data_out), 64'(i));
      chk("pt_dv1", 64'(bus1.data_valid), 64'd1);
      chk("pt_count", 64'(count0), 64'd16);
      chk("pt_noovf", 64'(ovf0), 64'd0);
    end

    // drain, then empty-side corner cases
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_dout1", 64'(bus1.data_out), 64'hABCD_EF01);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("udf_pulse", 64'(udf0), 64'd1);
    chk("udf_count", 64'(count0), 64'd0);
    cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    chk("pe_count", 64'(count0), 64'd1);
    chk("pe_udf", 64'(udf1), 64'd1);
    chk("pe_head0", 64'(bus0.data_out), 64'h1234_5678);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("pe_dout1", 64'(bus1.data_out), 64'h1234_5678);
    chk("pe_empty", 64'(empty1), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // interleaved traffic with pointer wrap
    for (int i = 0; i < 40; i++)
      cycle((i % 4) != 3, 32'hC0DE_0000 + 32'(i), (i % 3) == 0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // asynchronous reset at count 7
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'h5500 + 32'(i), 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count0), 64'd7);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_count0", 64'(count0), 64'd0);
    chk("arst_empty0", 64'(empty0), 64'd1);
    chk("arst_count1", 64'(count1), 64'd0);
    chk("arst_err", 64'(err0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 32'h0000_0077, 1'b0, 1'b0);
    chk("post_rst_count", 64'(count0), 64'd1);
    chk("post_rst_head0", 64'(bus0.data_out), 64'h77);

`ifdef SYNC_FIFO_P_PEAK_EN
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h6600 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("peak_count_now", 64'(count0), 64'd2);
    chk("peak_hold0", 64'(peak0), 64'd9);
    chk("peak_hold1", 64'(peak1), 64'd9);
    peak_clr_r = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    peak_clr_r = 1'b0;
    chk("peak_clr0", 64'(peak0), 64'd2);
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/sync_fifo_p.md
SYNC_FIFO_P -- requirements
Module: sync_fifo_p

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, legal range 1..256.
REQ-002 Parameter DEPTH_LOG2, default 4: storage depth is DEPTH = 2**DEPTH_LOG2 words, legal range 1..12.
REQ-003 Parameter ALMOST_FULL_TH, default 12: almost_full asserts when count >= this value, legal range 1..DEPTH.
REQ-004 Parameter ALMOST_EMPTY_TH, default 4: almost_empty asserts when count <= this value, legal range 0..DEPTH-1.
REQ-005 Parameter READ_MODE, default 0: 0 = show-ahead (head word visible on data_out), 1 = registered (data appears one cycle after pop).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 push  input  1  write request; data_in is written when the push is accepted.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 pop  input  1  read request.
REQ-011 err_clr  input  1  synchronous clear of the sticky error.
REQ-012 data_out  output  WIDTH  read data.
REQ-013 data_valid  output  1  data_out qualifier (see REQ-022, REQ-023).
REQ-014 count  output  DEPTH_LOG2+1  current number of stored words, range 0..DEPTH.
REQ-015 empty, almost_empty, almost_full, full  output  1 each  status flags, all derived from count.
REQ-016 overflow, underflow  output  1 each  one-cycle registered pulses, one cycle after the offending request.
REQ-017 error  output  1  sticky OR of overflow and underflow.

Function
REQ-018 Storage: DEPTH-entry array; wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap naturally from DEPTH-1 to 0.
REQ-019 count is an explicit register: +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither are accepted.
REQ-020 Flags: full = (count == DEPTH); empty = (count == 0); almost_full = (count >= ALMOST_FULL_TH); almost_empty = (count <= ALMOST_EMPTY_TH).
REQ-021 Acceptance: pop is accepted iff !empty; push is accepted iff !full OR (pop accepted in the same cycle).
  - A push on full with a simultaneous pop is accepted, and count stays at DEPTH.
  - A push on empty with a simultaneous pop: the push is accepted, the pop is rejected, and count becomes 1.
REQ-022 READ_MODE=0: data_out = mem[rd_ptr] combinationally; data_valid = !empty; a written word is visible the cycle after its push.
REQ-023 READ_MODE=1: on an accepted pop, data_out is loaded with mem[rd_ptr] at that edge and data_valid pulses for one cycle; otherwise data_out holds its value and data_valid = 0.
REQ-024 A rejected push is dropped, with no state change except overflow=1 for the next cycle; a rejected pop causes no state change except underflow=1 for the next cycle.
REQ-025 error is set by overflow or underflow and held until err_clr; if err_clr and a new overflow/underflow coincide, set wins.
REQ-026 X or Z on push or pop is treated as 0 for acceptance.

Reset
REQ-027 While reset_n=0: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, error=0, data_valid=0, data_out=0 (READ_MODE=1).
REQ-028 Reset asserted mid-operation discards all stored words immediately; memory contents are not cleared and are unobservable until rewritten.
REQ-029 The first push is accepted on the first rising edge after reset_n rises.

Configuration
REQ-030 Macro SYNC_FIFO_P_PEAK_EN defined: adds output peak_count (DEPTH_LOG2+1) and input peak_clr; peak_count holds the maximum count since reset or since the last peak_clr, updates one cycle after count; peak_clr loads the current count; reset value is 0.
REQ-031 Macro SYNC_FIFO_P_PEAK_EN not defined: the peak_count and peak_clr ports and their logic are absent; all other behaviour is identical.

Verification (defaults WIDTH=32, DEPTH_LOG2=4, ALMOST_FULL_TH=12, ALMOST_EMPTY_TH=4)
REQ-032 Fill: 16 pushes of data 0..15 from reset -> count reaches 16, full=1 after the 16th push, almost_full=1 from count 12, no overflow.
REQ-033 Overflow: when full, push=1 with pop=0 for 1 cycle -> overflow pulses 1 cycle, error=1 and sticky, count stays 16; err_clr -> error=0.
REQ-034 Full pass-through: when full, push+pop with data_in=32'hABCDEF01 for 4 cycles -> count stays 16, words 0..3 are read out in order, no overflow.
REQ-035 Empty: pop on empty -> underflow pulse, count=0; push+pop on empty with 32'h12345678 -> count=1, underflow pulse, and a following pop returns 32'h12345678.
REQ-036 Wrap and reset: 40 interleaved push/pop cycles in both READ_MODE values -> data matches a reference queue; reset_n pulled low at count=7 -> count=0, empty=1 asynchronously.
REQ-037 With SYNC_FIFO_P_PEAK_EN defined: fill to 9, drain to 2 -> peak_count=9; peak_clr -> peak_count=2.
